// File: rtl/kvs_seq_pkg.sv
// Shared types for the kvs command sequencer: op codes, FSM states, default-width payload structs.
package kvs_seq_pkg;

    localparam int unsigned KEY_BITS_DEF = 32;
    localparam int unsigned VAL_BITS_DEF = 32;
    localparam int unsigned TAG_BITS_DEF = 4;

    typedef enum logic [1:0] {
        OP_INSERT = 2'd0,
        OP_LOOKUP = 2'd1,
        OP_UPDATE = 2'd2,
        OP_DELETE = 2'd3
    } op_t;

    typedef enum logic {
        ST_ISSUE = 1'b0,
        ST_MOD   = 1'b1
    } seq_state_t;

    // Payload layouts at the default widths; parameterised instances pack the same field order.
    typedef struct packed {
        logic [KEY_BITS_DEF-1:0] key;
        logic [VAL_BITS_DEF-1:0] value;
    } ins_entry_t;

    typedef struct packed {
        op_t                     op;
        logic [TAG_BITS_DEF-1:0] tag;
        logic                    hit;
        logic [VAL_BITS_DEF-1:0] value;
    } resp_t;

    function automatic logic needs_modify(op_t op);
        return (op == OP_UPDATE) || (op == OP_DELETE);
    endfunction

endpackage

// File: rtl/kvs_cmd_sequencer_if.sv
// Command/response port of the kvs command sequencer (master = client, slave = sequencer).
interface kvs_cmd_sequencer_if
    import kvs_seq_pkg::*;
#(
    parameter int unsigned KEY_BITS = 32,
    parameter int unsigned VAL_BITS = 32,
    parameter int unsigned TAG_BITS = 4
);
    logic                cmd_valid;
    logic                cmd_ready;
    op_t                 cmd_op;
    logic [KEY_BITS-1:0] cmd_key;
    logic [VAL_BITS-1:0] cmd_value;
    logic [TAG_BITS-1:0] cmd_tag;

    logic                resp_valid;
    op_t                 resp_op;
    logic [TAG_BITS-1:0] resp_tag;
    logic                resp_hit;
    logic [VAL_BITS-1:0] resp_value;

    modport master (
        output cmd_valid, cmd_op, cmd_key, cmd_value, cmd_tag,
        input  cmd_ready,
        input  resp_valid, resp_op, resp_tag, resp_hit, resp_value
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_key, cmd_value, cmd_tag,
        output cmd_ready,
        output resp_valid, resp_op, resp_tag, resp_hit, resp_value
    );
endinterface

// File: rtl/kvs_seq_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible on rdata while not empty.
module kvs_seq_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

// File: rtl/kvs_cmd_sequencer.sv
// Command front-end for the kvs hashmap: insert queue, lookup->modify sequencing, tagged responses.
// Optional KVS_SEQ_STATS_EN adds saturating hit/miss/insert counters.
module kvs_cmd_sequencer
    import kvs_seq_pkg::*;
#(
    parameter int unsigned KEY_BITS       = 32,
    parameter int unsigned VAL_BITS       = 32,
    parameter int unsigned TAG_BITS       = 4,
    parameter int unsigned LOOKUP_LAT     = 3,
    parameter int unsigned INS_FIFO_DEPTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    kvs_cmd_sequencer_if.slave  cmd,
    output logic                kvs_insert,
    input  logic                kvs_busy,
    output logic [KEY_BITS-1:0] kvs_ins_key,
    output logic [VAL_BITS-1:0] kvs_ins_value,
    output logic                kvs_lookup,
    output logic [KEY_BITS-1:0] kvs_key,
    output logic                kvs_modify,
    output logic                kvs_del,
    output logic [VAL_BITS-1:0] kvs_mod_value,
    input  logic                kvs_valid,
    input  logic [VAL_BITS-1:0] kvs_value
`ifdef KVS_SEQ_STATS_EN
    ,
    output logic [31:0]         stat_hits,
    output logic [31:0]         stat_misses,
    output logic [31:0]         stat_inserts
`endif
);
    localparam int unsigned ENT_W = KEY_BITS + VAL_BITS;
    localparam int unsigned CNT_W = $clog2(INS_FIFO_DEPTH) + 1;

    seq_state_t          state_q, state_d;
    logic                ready_d;
    logic                lookup_d, modify_d, del_d;
    logic [KEY_BITS-1:0] key_d;
    logic [VAL_BITS-1:0] mod_value_d;
    logic [VAL_BITS-1:0] pend_val_q, pend_val_d;
    logic                pend_del_q, pend_del_d;

    logic                accept, push, acc_lk;
    logic [ENT_W-1:0]    fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count, cnt_nxt;

    logic                pipe_v_q   [LOOKUP_LAT+1];
    op_t                 pipe_op_q  [LOOKUP_LAT+1];
    logic [TAG_BITS-1:0] pipe_tag_q [LOOKUP_LAT+1];

    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign push   = accept && (cmd.cmd_op == OP_INSERT);
    assign acc_lk = accept && (cmd.cmd_op != OP_INSERT);

    // Insert drain bypasses the FSM: head goes out whenever kvs can take it.
    assign kvs_insert    = !fifo_empty && !kvs_busy;
    assign kvs_ins_key   = fifo_rdata[ENT_W-1:VAL_BITS];
    assign kvs_ins_value = fifo_rdata[VAL_BITS-1:0];

    kvs_seq_fifo #(
        .DEPTH (INS_FIFO_DEPTH),
        .WIDTH (ENT_W)
    ) u_ins_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({cmd.cmd_key, cmd.cmd_value}),
        .pop   (kvs_insert),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next state and next values of every registered kvs/handshake output.
    always_comb begin
        state_d     = state_q;
        lookup_d    = 1'b0;
        key_d       = kvs_key;
        modify_d    = 1'b0;
        del_d       = 1'b0;
        mod_value_d = '0;
        pend_val_d  = pend_val_q;
        pend_del_d  = pend_del_q;
        unique case (state_q)
            ST_ISSUE: begin
                if (acc_lk) begin
                    lookup_d = 1'b1;
                    key_d    = cmd.cmd_key;
                    if (needs_modify(cmd.cmd_op)) begin
                        state_d    = ST_MOD;
                        pend_val_d = cmd.cmd_value;
                        pend_del_d = (cmd.cmd_op == OP_DELETE);
                    end
                end
            end
            ST_MOD: begin
                modify_d    = 1'b1;
                del_d       = pend_del_q;
                mod_value_d = pend_del_q ? '0 : pend_val_q;
                state_d     = ST_ISSUE;
            end
            default: state_d = ST_ISSUE;
        endcase
        cnt_nxt = fifo_count + CNT_W'(push) - CNT_W'(kvs_insert);
        ready_d = (state_d == ST_ISSUE) && (cnt_nxt != CNT_W'(INS_FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_ISSUE;
            cmd.cmd_ready <= 1'b0;
            kvs_lookup    <= 1'b0;
            kvs_key       <= '0;
            kvs_modify    <= 1'b0;
            kvs_del       <= 1'b0;
            kvs_mod_value <= '0;
            pend_val_q    <= '0;
            pend_del_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cmd.cmd_ready <= ready_d;
            kvs_lookup    <= lookup_d;
            kvs_key       <= key_d;
            kvs_modify    <= modify_d;
            kvs_del       <= del_d;
            kvs_mod_value <= mod_value_d;
            pend_val_q    <= pend_val_d;
            pend_del_q    <= pend_del_d;
        end
    end

    // Stage 0 is loaded alongside kvs_lookup; the last stage lines up with kvs data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k <= LOOKUP_LAT; k++) begin
                pipe_v_q[k]   <= 1'b0;
                pipe_op_q[k]  <= OP_INSERT;
                pipe_tag_q[k] <= '0;
            end
        end else begin
            pipe_v_q[0]   <= acc_lk;
            pipe_op_q[0]  <= cmd.cmd_op;
            pipe_tag_q[0] <= cmd.cmd_tag;
            for (int unsigned k = 1; k <= LOOKUP_LAT; k++) begin
                pipe_v_q[k]   <= pipe_v_q[k-1];
                pipe_op_q[k]  <= pipe_op_q[k-1];
                pipe_tag_q[k] <= pipe_tag_q[k-1];
            end
        end
    end

    assign cmd.resp_valid = pipe_v_q[LOOKUP_LAT];
    assign cmd.resp_op    = pipe_op_q[LOOKUP_LAT];
    assign cmd.resp_tag   = pipe_tag_q[LOOKUP_LAT];
    assign cmd.resp_hit   = pipe_v_q[LOOKUP_LAT] && kvs_valid;
    assign cmd.resp_value = pipe_v_q[LOOKUP_LAT] ? kvs_value : '0;

`ifdef KVS_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hits    <= '0;
            stat_misses  <= '0;
            stat_inserts <= '0;
        end else begin
            if (cmd.resp_valid && kvs_valid && (stat_hits != '1))
                stat_hits <= stat_hits + 32'd1;
            if (cmd.resp_valid && !kvs_valid && (stat_misses != '1))
                stat_misses <= stat_misses + 32'd1;
            if (kvs_insert && (stat_inserts != '1))
                stat_inserts <= stat_inserts + 32'd1;
        end
    end
`endif

endmodule
